// File: rtl/bit_ops_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_ops_pkg
// Description : Shared constants for the bit-serial logic unit: the opcode
//               encoding of the 1-bit evaluator and the controller state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_ops_pkg;

    // Opcode encoding (3 bits, sampled together with start_in)
    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_NAND    = 3'd1;
    localparam logic [2:0] OP_OR      = 3'd2;
    localparam logic [2:0] OP_NOR     = 3'd3;
    localparam logic [2:0] OP_XOR     = 3'd4;
    localparam logic [2:0] OP_XNOR    = 3'd5;
    localparam logic [2:0] OP_NOTA    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Controller state encoding
    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

endpackage : bit_ops_pkg
`default_nettype wire

// File: rtl/bit_op_slice.sv
`default_nettype none
// ============================================================================
// Module      : bit_op_slice
// Description : Combinational 1-bit logic evaluator.
// Ports       : a, b    - operand bits
//               op      - 3-bit opcode (see bit_ops_pkg)
//               y       - result bit (0 for the illegal opcode)
//               illegal - high when op is the illegal opcode
// Revision    : 1.0 - initial release
// ============================================================================
module bit_op_slice
    import bit_ops_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y,
    output logic       illegal
);

    always_comb begin
        y       = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            default: illegal = 1'b1;
        endcase
    end

endmodule : bit_op_slice
`default_nettype wire

// File: rtl/bit_serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_logic_unit
// Description : Evaluates a bitwise logic operation on two WIDTH-bit operands
//               one bit per clock, LSB first, streaming each bit on ser_out
//               and assembling the parallel result.
// Parameters  : WIDTH (2..32) operand/result width
// Ports       : clk_in, reset_in (async, active-high)
//               start_in, op_in, a_in, b_in  - request (accepted in IDLE)
//               busy_out                      - operation in progress
//               ser_out, ser_valid_out        - serial result stream
//               result_out, done_out, err_out - completion interface
//               parity_out                    - XOR of result_out
//                                               (only with BSLU_PARITY_EN)
// Build macro : BSLU_PARITY_EN adds the parity_out port.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_logic_unit
    import bit_ops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             ser_out,
    output logic             ser_valid_out,
    output logic [WIDTH-1:0] result_out,
    output logic             done_out,
    output logic             err_out
`ifdef BSLU_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    // One extra counter bit so a power-of-two WIDTH never wraps the count.
    localparam int                CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(WIDTH - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2:0]           r_op;
    logic [CNT_W-1:0]     r_count;
    logic [WIDTH-1:0]     r_result;

    logic                 w_y;
    logic                 w_illegal;
    logic                 w_accept;

    assign w_accept = (r_state == c_st_idle) && start_in;

    // Operands are shifted right, so the slice always looks at bit 0.
    bit_op_slice u_slice (
        .a       (r_a[0]),
        .b       (r_b[0]),
        .op      (r_op),
        .y       (w_y),
        .illegal (w_illegal)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (start_in)          w_next_state = c_st_shift;
            c_st_shift: if (r_count == c_last) w_next_state = c_st_done;
            c_st_done:                         w_next_state = c_st_idle;
            default:                           w_next_state = c_st_idle;
        endcase
    end

    // ---------------- output logic ----------------
    // All status outputs decode from the state register, so an asynchronous
    // reset drives them low immediately.
    always_comb begin
        busy_out      = 1'b0;
        ser_valid_out = 1'b0;
        ser_out       = 1'b0;
        done_out      = 1'b0;
        err_out       = 1'b0;
        case (r_state)
            c_st_shift: begin
                busy_out      = 1'b1;
                ser_valid_out = 1'b1;
                ser_out       = w_y;
            end
            c_st_done: begin
                busy_out = 1'b1;
                done_out = 1'b1;
                err_out  = w_illegal;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_AND;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_op     <= op_in;
            r_count  <= '0;
            r_result <= '0;
        end else if (r_state == c_st_shift) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_count  <= r_count + 1'b1;
            // Result was cleared on acceptance, so OR-ing the bit in at
            // position r_count places it without a variable-width select.
            r_result <= r_result | ({{(WIDTH-1){1'b0}}, w_y} << r_count);
        end
    end

    assign result_out = r_result;

`ifdef BSLU_PARITY_EN
    assign parity_out = ^r_result;
`endif

endmodule : bit_serial_logic_unit
`default_nettype wire

// File: tb/tb_bit_serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_logic_unit
// Description : Self-checking bench for bit_serial_logic_unit (WIDTH=8).
//               Directed cases plus randomized operations compared against a
//               whole-word reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_logic_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         ser;
    logic         ser_valid;
    logic [W-1:0] result;
    logic         done;
    logic         err;
`ifdef BSLU_PARITY_EN
    logic         parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_logic_unit #(.WIDTH(W)) dut (
        .clk_in        (clk),
        .reset_in      (rst),
        .start_in      (start),
        .op_in         (op),
        .a_in          (a),
        .b_in          (b),
        .busy_out      (busy),
        .ser_out       (ser),
        .ser_valid_out (ser_valid),
        .result_out    (result),
        .done_out      (done),
        .err_out       (err)
`ifdef BSLU_PARITY_EN
        ,
        .parity_out    (parity)
`endif
    );

    // Whole-word reference: the result of the opcode applied to all bits.
    function automatic logic [W-1:0] ref_result(input logic [2:0] o,
                                                input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return ~(x & y);
            3'd2:    return x | y;
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".ser_valid"}, 32'(ser_valid), 32'd0);
        check({tag, ".ser"},       32'(ser),       32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".err"},       32'(err),       32'd0);
    endtask

    // Issue one operation and check every cycle up to the return to IDLE.
    // inject > 0 pulses a conflicting start in that SHIFT cycle.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp, input int inject);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        for (int c = 1; c <= W; c++) begin
            check({tag, ".busy"},      32'(busy),      32'd1);
            check({tag, ".ser_valid"}, 32'(ser_valid), 32'd1);
            check({tag, ".ser"},       32'(ser),       32'(exp[c-1]));
            check({tag, ".no_done"},   32'(done),      32'd0);
            if (c == inject) begin
                start = 1'b1; a = '1; b = '1; op = 3'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".done"},       32'(done),      32'd1);
        check({tag, ".busy_done"},  32'(busy),      32'd1);
        check({tag, ".valid_done"}, 32'(ser_valid), 32'd0);
        check({tag, ".ser_done"},   32'(ser),       32'd0);
        check({tag, ".result"},     32'(result),    32'(exp));
        check({tag, ".err"},        32'(err),       32'(o == 3'd7));
`ifdef BSLU_PARITY_EN
        check({tag, ".parity"},     32'(parity),    32'(^exp));
`endif
        @(negedge clk);
        check_idle_outputs({tag, ".after"});
        check({tag, ".held"}, 32'(result), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check_idle_outputs("reset");
        check("reset.result", 32'(result), 32'd0);
`ifdef BSLU_PARITY_EN
        check("reset.parity", 32'(parity), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived results
        run_op("and",   3'd0, 8'hA5, 8'h0F, 8'h05, 0);
        run_op("xnor",  3'd5, 8'hA5, 8'h0F, 8'h55, 0);
        run_op("nor",   3'd3, 8'hA5, 8'h0F, 8'h50, 0);
        run_op("nota",  3'd6, 8'hA5, 8'h0F, 8'h5A, 0);
        run_op("or",    3'd2, 8'hA5, 8'h0F, 8'hAF, 0);
        run_op("or1",   3'd2, 8'h01, 8'h00, 8'h01, 0);
        run_op("nand",  3'd1, 8'hA5, 8'h0F, 8'hFA, 0);
        run_op("xor_ignore", 3'd4, 8'hA5, 8'h0F, 8'hAA, 3);
        run_op("illegal", 3'd7, 8'hA5, 8'h0F, 8'h00, 0);

        // Reset in cycle 4 of an OR operation
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 8'hA5; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        check("midreset.result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < W + 3; c++) begin
            check("midreset.no_done", 32'(done), 32'd0);
            check("midreset.no_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        run_op("post_reset", 3'd2, 8'hA5, 8'h0F, 8'hAF, 0);

        // Randomized operations, including the illegal opcode
        for (int i = 0; i < 24; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("rand", ro, ra, rb, ref_result(ro, ra, rb),
                   (i % 4 == 0) ? int'($urandom_range(1, W)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bit_serial_logic_unit
`default_nettype wire

// File: doc/bit_serial_logic_unit.md
BIT_SERIAL_LOGIC_UNIT -- requirements
Module: bit_serial_logic_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 reset_in  input  1  reset, asynchronous, active-high.
REQ-004 start_in  input  1  request pulse; accepted only in IDLE.
REQ-005 op_in  input  3  opcode, sampled with start_in.
REQ-006 a_in  input  WIDTH  operand A, sampled with start_in.
REQ-007 b_in  input  WIDTH  operand B, sampled with start_in.
REQ-008 busy_out  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-009 ser_out  output  1  current serial result bit, LSB first.
REQ-010 ser_valid_out  output  1  ser_out is valid this cycle.
REQ-011 result_out  output  WIDTH  parallel result; valid while done_out is high, then held until the next acceptance.
REQ-012 done_out  output  1  one-cycle completion pulse.
REQ-013 err_out  output  1  illegal opcode flag, valid with done_out.

Function
REQ-014 The opcodes SHALL be 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (B ignored), and 7 illegal.
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE; IDLE -> SHIFT on start_in; SHIFT -> DONE after WIDTH bits; DONE -> IDLE unconditionally after one cycle.
REQ-016 On acceptance, the block SHALL latch a_in, b_in and op_in into shift registers, clear the bit counter and clear result_out.
REQ-017 In each SHIFT cycle, the block SHALL evaluate one bit pair (index = counter), drive ser_out with ser_valid_out=1, and shift that bit into result bit [counter].
REQ-018 Timing: start at edge 0 -> first ser_valid_out in cycle 1 -> last bit in cycle WIDTH -> done_out in cycle WIDTH+1.
REQ-019 start_in in SHIFT or DONE SHALL be ignored, with no queuing and no corruption of the operation in progress.
REQ-020 For opcode 7, the block SHALL run the full WIDTH-cycle sequence, drive ser_out=0 and a result of all zeros, and assert err_out with done_out.
REQ-021 The counter SHALL be $clog2(WIDTH)+1 bits wide, so that WIDTH equal to a power of two terminates without wrap-around.
REQ-022 ser_out SHALL be 0 whenever ser_valid_out is 0.

Reset
REQ-023 reset_in SHALL force IDLE asynchronously and clear every output to 0: busy_out, ser_out, ser_valid_out, result_out, done_out and err_out.
REQ-024 Reset asserted mid-SHIFT SHALL abandon the operation, with no done_out pulse afterwards.
REQ-025 The first start_in after reset deassertion SHALL be accepted normally.

Configuration
REQ-026 Macro BSLU_PARITY_EN: when defined, the block SHALL add output parity_out (1 bit) holding the even parity (XOR) of result_out, valid with done_out and reset to 0.
REQ-027 Without BSLU_PARITY_EN, the parity_out port and its logic SHALL be absent.

Structure
REQ-028 Package bit_ops_pkg SHALL hold the opcode constants (OP_AND..OP_NOTA, OP_ILLEGAL) and the FSM state encoding.
REQ-029 Sub-module bit_op_slice SHALL implement the combinational 1-bit evaluator with inputs a, b and op and outputs y and illegal.

Verification
REQ-030 WIDTH=8, a=0xA5, b=0x0F, op=AND -> ser bits 1,0,1,0,0,0,0,0 in cycles 1..8; done in cycle 9 with result 0x05 and err 0.
REQ-031 a=0xA5, b=0x0F, op=XNOR -> result 0x55; op=NOR -> 0x50; op=NOT A -> 0x5A.
REQ-032 op=XOR running; start_in with a=0xFF pulsed in cycle 3 -> ignored; result 0xAA; exactly one done pulse.
REQ-033 reset_in asserted in cycle 4 of OR -> all outputs 0 immediately; no done pulse; next start completes correctly.
REQ-034 op=7 -> 8 valid cycles with ser_out=0; result 0x00 with err_out=1 on done.
REQ-035 With BSLU_PARITY_EN, a=0xA5, b=0x0F, op=OR (result 0xAF) -> parity_out=0; op=AND (result 0x05) -> parity_out=0; a=0x01, b=0x00, op=OR -> parity_out=1.
